pcs_tx_sched: RTL and testbench

PCS_TX_SCHED -- requirements
Module: pcs_tx_sched

---
 rtl/pcs_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_pcs_tx_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_sched
// Brief    : Frames MAC beats into start/data/terminate/error/idle blocks for
//            a 64b/66b PCS encoder, enforcing a minimum inter-packet gap.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_sched #(
    parameter int IPG_MIN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [63:0]      s_data_i,
    input  logic [7:0]       s_keep_i,
    input  logic             s_last_i,
    output logic             ctrl_v_o,
    output logic             idle_v_o,
    output logic             start_v_o,
    output logic             term_v_o,
    output logic             err_v_o,
    output logic [63:0]      data_o,
    output logic [2:0]       term_cnt_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int               IPG_W       = $clog2(IPG_MIN + 2);
    localparam logic [IPG_W-1:0] c_IPG_SAT   = IPG_W'(IPG_MIN);
    localparam logic [63:0]      c_START_BLK = 64'hD555_5555_5555_5500;
    localparam logic [63:0]      c_ERR_BLK   = 64'h1E1E_1E1E_1E1E_1E00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_TERM0 = 3'd2,
        ST_DROP  = 3'd3,
        ST_IPG   = 3'd4
    } state_t;

    state_t           r_state;
    logic [IPG_W-1:0] r_ipg_cnt;
    logic             r_ctrl_v;
    logic             r_idle_v;
    logic             r_start_v;
    logic             r_term_v;
    logic             r_err_v;
    logic [63:0]      r_data;
    logic [2:0]       r_term_cnt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [3:0]       w_popcnt;
    logic [63:0]      w_term_data;
    logic             w_ipg_ok;
    logic [IPG_W-1:0] w_ipg_nxt;
    logic [CNT_W-1:0] w_frame_nxt;
    logic [CNT_W-1:0] w_err_nxt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 8; i++) begin
            w_popcnt = w_popcnt + 4'(s_keep_i[i]);
        end
    end

    // Terminate payload: the n valid bytes move up one lane, lane 0 is the control code.
    always_comb begin
        w_term_data = '0;
        for (int i = 0; i < 7; i++) begin
            if (4'(i) < w_popcnt) begin
                w_term_data[8*(i+1) +: 8] = s_data_i[8*i +: 8];
            end
        end
    end

    assign w_ipg_ok    = (r_ipg_cnt == c_IPG_SAT);
    assign w_ipg_nxt   = w_ipg_ok ? r_ipg_cnt : r_ipg_cnt + IPG_W'(1);
    assign w_frame_nxt = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);
    assign w_err_nxt   = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);

    assign s_ready_o   = (r_state == ST_DATA) || (r_state == ST_DROP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ipg_cnt   <= c_IPG_SAT;
            r_ctrl_v    <= 1'b1;
            r_idle_v    <= 1'b1;
            r_start_v   <= 1'b0;
            r_term_v    <= 1'b0;
            r_err_v     <= 1'b0;
            r_data      <= '0;
            r_term_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            // Idle block unless a state below decides otherwise.
            r_ctrl_v   <= 1'b1;
            r_idle_v   <= 1'b1;
            r_start_v  <= 1'b0;
            r_term_v   <= 1'b0;
            r_err_v    <= 1'b0;
            r_data     <= '0;
            r_term_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (s_valid_i && w_ipg_ok) begin
                        r_idle_v  <= 1'b0;
                        r_start_v <= 1'b1;
                        r_data    <= c_START_BLK;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (!s_valid_i) begin
                        r_idle_v  <= 1'b0;
                        r_err_v   <= 1'b1;
                        r_data    <= c_ERR_BLK;
                        r_err_cnt <= w_err_nxt;
                        r_ipg_cnt <= '0;
                        r_state   <= ST_DROP;
                    end else if (!s_last_i || (w_popcnt == 4'd8)) begin
                        r_ctrl_v <= 1'b0;
                        r_idle_v <= 1'b0;
                        r_data   <= s_data_i;
                        if (s_last_i) begin
                            r_state <= ST_TERM0;
                        end
                    end else begin
                        r_idle_v    <= 1'b0;
                        r_term_v    <= 1'b1;
                        r_term_cnt  <= w_popcnt[2:0];
                        r_data      <= w_term_data;
                        r_frame_cnt <= w_frame_nxt;
                        r_ipg_cnt   <= '0;
                        r_state     <= ST_IPG;
                    end
                end

                ST_TERM0: begin
                    r_idle_v    <= 1'b0;
                    r_term_v    <= 1'b1;
                    r_frame_cnt <= w_frame_nxt;
                    r_ipg_cnt   <= '0;
                    r_state     <= ST_IPG;
                end

                // Idles emitted while draining an errored frame count toward the gap.
                ST_DROP: begin
                    r_ipg_cnt <= w_ipg_nxt;
                    if (s_valid_i && s_last_i) begin
                        r_state <= ST_IPG;
                    end
                end

                ST_IPG: begin
                    r_ipg_cnt <= w_ipg_nxt;
                    if (w_ipg_nxt == c_IPG_SAT) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_v_o    = r_ctrl_v;
    assign idle_v_o    = r_idle_v;
    assign start_v_o   = r_start_v;
    assign term_v_o    = r_term_v;
    assign err_v_o     = r_err_v;
    assign data_o      = r_data;
    assign term_cnt_o  = r_term_cnt;
    assign frame_cnt_o = r_frame_cnt;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_tx_sched
// Brief    : Self-checking bench for pcs_tx_sched with a block-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_sched;

    localparam int CW = 4;
    localparam int K_IDLE  = 0;
    localparam int K_START = 1;
    localparam int K_DATA  = 2;
    localparam int K_TERM  = 3;
    localparam int K_ERR   = 4;
    localparam int K_BAD   = 5;
    localparam logic [63:0] c_START = 64'hD555_5555_5555_5500;
    localparam logic [63:0] c_ERR   = 64'h1E1E_1E1E_1E1E_1E00;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [63:0]   s_data_i = '0;
    logic [7:0]    s_keep_i = '0;
    logic          s_last_i = 1'b0;
    logic          ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
    logic [63:0]   data_o;
    logic [2:0]    term_cnt_o;
    logic [CW-1:0] frame_cnt_o, err_cnt_o;

    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [63:0]   b_data = '0;
    logic [7:0]    b_keep = '0;
    logic          b_last = 1'b0;
    logic          b_ctrl, b_idle, b_start, b_term, b_err;
    logic [63:0]   b_data_o;
    logic [2:0]    b_tcnt;
    logic [CW-1:0] b_fcnt, b_ecnt;

    always #5 clk = ~clk;

    pcs_tx_sched #(.IPG_MIN(1), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_keep_i(s_keep_i), .s_last_i(s_last_i),
        .ctrl_v_o(ctrl_v_o), .idle_v_o(idle_v_o), .start_v_o(start_v_o),
        .term_v_o(term_v_o), .err_v_o(err_v_o), .data_o(data_o),
        .term_cnt_o(term_cnt_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
    );

    pcs_tx_sched #(.IPG_MIN(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .reset(reset),
        .s_valid_i(b_valid), .s_ready_o(b_ready), .s_data_i(b_data),
        .s_keep_i(b_keep), .s_last_i(b_last),
        .ctrl_v_o(b_ctrl), .idle_v_o(b_idle), .start_v_o(b_start),
        .term_v_o(b_term), .err_v_o(b_err), .data_o(b_data_o),
        .term_cnt_o(b_tcnt), .frame_cnt_o(b_fcnt), .err_cnt_o(b_ecnt)
    );

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [2:0]  tcnt;
        int          stamp;   // observed: cycle; expected: cycle distance to previous block, -1 = any
    } blk_t;

    blk_t obs_q[$];
    blk_t exp_q[$];
    int   kq_b[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   bad_cnt = 0;
    int   model_frames = 0;
    int   model_errs = 0;
    bit   rdy_hist [0:4095];

    function automatic int blk_kind(input logic c, input logic i, input logic s,
                                    input logic t, input logic e);
        int n;
        n = int'(i) + int'(s) + int'(t) + int'(e);
        if (!c) return (n == 0) ? K_DATA : K_BAD;
        if (n != 1) return K_BAD;
        if (i) return K_IDLE;
        if (s) return K_START;
        if (t) return K_TERM;
        return K_ERR;
    endfunction

    function automatic int sat(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rdy_hist[cyc % 4096] <= s_ready_o;
        if (!reset) begin
            if (blk_kind(ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o) != K_IDLE)
                obs_q.push_back('{blk_kind(ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o),
                                  data_o, term_cnt_o, cyc});
            if (blk_kind(ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o) == K_BAD ||
                (idle_v_o && data_o != 64'd0))
                bad_cnt <= bad_cnt + 1;
            kq_b.push_back(blk_kind(b_ctrl, b_idle, b_start, b_term, b_err));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_wait(input int n);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int w;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_keep_i  = k;
        s_last_i  = l;
        w = 0;
        @(negedge clk);
        while (!s_ready_o && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready_o) chk("handshake_timeout", 64'(s_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Builds the expected block list from the frame description, then drives it.
    task automatic send_frame(input int nb, input logic [7:0] lk, input int ur, input int gap);
        logic [63:0] d;
        int n;
        exp_q.push_back('{K_START, c_START, 3'd0, gap});
        for (int b = 1; b <= nb; b++) begin
            d = {$urandom, $urandom};
            if (b < nb) begin
                send_beat(d, 8'($urandom), 1'b0);
                if (ur == 0 || b <= ur) exp_q.push_back('{K_DATA, d, 3'd0, 1});
                if (b == ur) begin
                    s_valid_i = 1'b0;
                    @(posedge clk);
                    #1;
                    exp_q.push_back('{K_ERR, c_ERR, 3'd0, 1});
                    model_errs = sat(model_errs);
                end
            end else begin
                send_beat(d, lk, 1'b1);
                if (ur == 0) begin
                    if (lk == 8'hFF) begin
                        exp_q.push_back('{K_DATA, d, 3'd0, 1});
                        exp_q.push_back('{K_TERM, 64'd0, 3'd0, 1});
                    end else begin
                        n = $countones(lk);
                        exp_q.push_back('{K_TERM, (d & ((64'd1 << (8 * n)) - 64'd1)) << 8,
                                          3'(n), 1});
                    end
                    model_frames = sat(model_frames);
                end
            end
        end
    endtask

    task automatic check_frames(input string tag);
        idle_wait(6);
        chk({tag, "_nblk"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_kind%0d", tag, i), 64'(obs_q[i].kind), 64'(exp_q[i].kind));
            chk($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("%s_tcnt%0d", tag, i), 64'(obs_q[i].tcnt), 64'(exp_q[i].tcnt));
            if (i > 0 && exp_q[i].stamp >= 0)
                chk($sformatf("%s_gap%0d", tag, i), 64'(obs_q[i].stamp - obs_q[i-1].stamp),
                    64'(exp_q[i].stamp));
        end
        chk({tag, "_flag_rules"}, 64'(bad_cnt), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt_o), 64'(model_frames));
        chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(model_errs));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        s_valid_i = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_frames = 0;
        model_errs = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nby, ur, c, j, nchk;
        logic [7:0] lk;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl_v", 64'(ctrl_v_o), 64'd1);
        chk("rst_idle_v", 64'(idle_v_o), 64'd1);
        chk("rst_other_flags", 64'({start_v_o, term_v_o, err_v_o}), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_term_cnt", 64'(term_cnt_o), 64'd0);
        chk("rst_ready", 64'(s_ready_o), 64'd0);
        chk("rst_counters", 64'({frame_cnt_o, err_cnt_o}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_wait(3);

        // 3-beat frame, keep 0x07 on the last beat
        send_frame(3, 8'h07, 0, -1);
        check_frames("f3_keep07");
        chk("f3_keep07_frame_is_1", 64'(frame_cnt_o), 64'd1);

        // Full last beat then back-to-back frame with non-contiguous keep
        send_frame(2, 8'hFF, 0, -1);
        send_frame(1, 8'hA5, 0, 2);
        chk("term0_present", 64'(obs_q.size() > 3), 64'd1);
        if (obs_q.size() > 3) begin
            c = obs_q[3].stamp;
            chk("term0_ready_low", 64'(rdy_hist[(c - 1) % 4096]), 64'd0);
            chk("data_ready_high", 64'(rdy_hist[(c - 2) % 4096]), 64'd1);
        end
        check_frames("f2_keepff_b2b");

        // Underrun after beat 1 of 4
        do_reset();
        idle_wait(2);
        send_frame(4, 8'h0F, 1, -1);
        check_frames("underrun");
        chk("underrun_err_is_1", 64'(err_cnt_o), 64'd1);
        chk("underrun_frame_is_0", 64'(frame_cnt_o), 64'd0);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            nb  = $urandom_range(1, 4);
            nby = $urandom_range(0, 8);
            lk  = (nby == 8) ? 8'hFF : 8'((1 << nby) - 1);
            ur  = (nb >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, nb - 1) : 0;
            idle_wait($urandom_range(0, 3));
            send_frame(nb, lk, ur, -1);
            check_frames($sformatf("rnd%0d", f));
        end

        // Reset in the middle of a frame
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_idle_v", 64'(idle_v_o), 64'd1);
        chk("midrst_ctrl_v", 64'(ctrl_v_o), 64'd1);
        chk("midrst_ready", 64'(s_ready_o), 64'd0);
        chk("midrst_counters", 64'({frame_cnt_o, err_cnt_o}), 64'd0);
        model_frames = 0;
        model_errs = 0;
        obs_q.delete();
        exp_q.delete();
        idle_wait(5);
        chk("midrst_no_term_or_err", 64'(obs_q.size()), 64'd0);
        obs_q.delete();

        // Frame counter saturation
        for (int f = 0; f < (1 << CW) + 2; f++) begin
            nby = $urandom_range(0, 8);
            lk  = (nby == 8) ? 8'hFF : 8'((1 << nby) - 1);
            send_frame($urandom_range(1, 2), lk, 0, -1);
            check_frames($sformatf("sat%0d", f));
        end
        chk("frame_cnt_saturated", 64'(frame_cnt_o), 64'((1 << CW) - 1));

        // IPG_MIN=3 instance with valid held high
        kq_b.delete();
        b_valid = 1'b1;
        b_last  = 1'b1;
        b_keep  = 8'h01;
        b_data  = {$urandom, $urandom};
        repeat (40) @(posedge clk);
        #1;
        b_valid = 1'b0;
        nchk = 0;
        for (int i = 0; i < kq_b.size(); i++) begin
            if (kq_b[i] == K_TERM) begin
                j = i + 1;
                while (j < kq_b.size() && kq_b[j] == K_IDLE) j++;
                if (j < kq_b.size()) begin
                    chk($sformatf("ipg3_idles_%0d", i), 64'(j - i - 1), 64'd3);
                    chk($sformatf("ipg3_next_start_%0d", i), 64'(kq_b[j]), 64'(K_START));
                    nchk++;
                end
            end
        end
        chk("ipg3_gaps_seen", 64'(nchk >= 3), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
